// File: rtl/serial_port_ctrl.sv
// CPU-side controller for the serial_port block: TX/RX byte FIFOs, DATA/STATUS/CTRL registers,
// transmit strobe sequencing, receive handshake and a single level interrupt.
module serial_port_ctrl #(
  parameter int TX_AW = 4,
  parameter int RX_AW = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] bus_addr,
  input  logic       bus_rd,
  input  logic       bus_wr,
  input  logic [7:0] bus_wdata,
  output logic [7:0] bus_rdata,
  output logic       irq,
  output logic [7:0] sp_data_in,
  output logic       sp_write_en,
  input  logic       sp_write_busy,
  input  logic       sp_int_req,
  output logic       sp_int_ack,
  input  logic [7:0] sp_data_out
);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_WAIT_HI, TX_WAIT_LO} tx_state_t;
  typedef enum logic {RX_WAIT, RX_ACK} rx_state_t;

  localparam logic [TX_AW:0] TX_FULL_DIFF = {1'b1, {TX_AW{1'b0}}};
  localparam logic [RX_AW:0] RX_FULL_DIFF = {1'b1, {RX_AW{1'b0}}};

  logic [7:0]     tx_mem [1 << TX_AW];
  logic [7:0]     rx_mem [1 << RX_AW];
  logic [TX_AW:0] tx_wr_ptr, tx_rd_ptr;
  logic [RX_AW:0] rx_wr_ptr, rx_rd_ptr;

  tx_state_t tx_state, tx_next;
  rx_state_t rx_state, rx_next;
  logic      tx_hi_wait;
  logic      tx_ovf, rx_ovr, rx_ie, tx_ie;

  logic tx_empty, tx_full, rx_empty, rx_full, tx_idle;
  logic wr_data, wr_status, wr_ctrl, rd_data;
  logic tx_launch, tx_push, tx_ovf_set;
  logic rx_take, rx_pop, rx_push, rx_ovr_set;
  logic [7:0] status, rd_value;

  assign tx_empty = (tx_wr_ptr == tx_rd_ptr);
  assign tx_full  = ((tx_wr_ptr ^ tx_rd_ptr) == TX_FULL_DIFF);
  assign rx_empty = (rx_wr_ptr == rx_rd_ptr);
  assign rx_full  = ((rx_wr_ptr ^ rx_rd_ptr) == RX_FULL_DIFF);
  assign tx_idle  = tx_empty && (tx_state == TX_IDLE) && !sp_write_busy;

  assign wr_data   = bus_wr && (bus_addr == 2'd0);
  assign wr_status = bus_wr && (bus_addr == 2'd1);
  assign wr_ctrl   = bus_wr && (bus_addr == 2'd2);
  assign rd_data   = bus_rd && (bus_addr == 2'd0);

  // A pop in the same cycle frees a slot, so a push into a full FIFO is still accepted.
  assign tx_push    = wr_data && (!tx_full || tx_launch);
  assign tx_ovf_set = wr_data && tx_full && !tx_launch;
  assign rx_take    = (rx_state == RX_WAIT) && sp_int_req;
  assign rx_pop     = rd_data && !rx_empty;
  assign rx_push    = rx_take && (!rx_full || rx_pop);
  assign rx_ovr_set = rx_take && rx_full && !rx_pop;

  assign status = {3'b000, tx_ovf, rx_ovr, tx_idle, tx_full, !rx_empty};

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    tx_next   = tx_state;
    tx_launch = 1'b0;
    unique case (tx_state)
      TX_IDLE: begin
        if (!tx_empty && !sp_write_busy) begin
          tx_launch = 1'b1;
          tx_next   = TX_START;
        end
      end
      TX_START:   tx_next = TX_WAIT_HI;
      TX_WAIT_HI: begin
        // The transmitter gets two cycles to raise busy; otherwise the byte is considered lost.
        if (sp_write_busy)   tx_next = TX_WAIT_LO;
        else if (tx_hi_wait) tx_next = TX_IDLE;
      end
      TX_WAIT_LO: if (!sp_write_busy) tx_next = TX_IDLE;
      default:    tx_next = TX_IDLE;
    endcase
  end

  always_comb begin
    rx_next = rx_state;
    unique case (rx_state)
      RX_WAIT: if (sp_int_req) rx_next = RX_ACK;
      RX_ACK:  rx_next = RX_WAIT;
      default: rx_next = RX_WAIT;
    endcase
  end

  always_comb begin
    rd_value = 8'h00;
    unique case (bus_addr)
      2'd0:    rd_value = rx_empty ? 8'h00 : rx_mem[rx_rd_ptr[RX_AW-1:0]];
      2'd1:    rd_value = status;
      2'd2:    rd_value = {6'b000000, tx_ie, rx_ie};
      default: rd_value = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: registers use non-blocking assignments so each one samples the values from before the edge.
    if (rst) begin
      tx_state    <= TX_IDLE;
      rx_state    <= RX_WAIT;
      tx_hi_wait  <= 1'b0;
      tx_wr_ptr   <= '0;
      tx_rd_ptr   <= '0;
      rx_wr_ptr   <= '0;
      rx_rd_ptr   <= '0;
      tx_ovf      <= 1'b0;
      rx_ovr      <= 1'b0;
      rx_ie       <= 1'b0;
      tx_ie       <= 1'b0;
      bus_rdata   <= 8'h00;
      irq         <= 1'b0;
      sp_data_in  <= 8'h00;
      sp_write_en <= 1'b0;
      sp_int_ack  <= 1'b0;
    end else begin
      tx_state    <= tx_next;
      rx_state    <= rx_next;
      tx_hi_wait  <= (tx_state == TX_WAIT_HI);
      sp_write_en <= tx_launch;
      sp_int_ack  <= rx_take;
      if (tx_launch) begin
        sp_data_in <= tx_mem[tx_rd_ptr[TX_AW-1:0]];
        tx_rd_ptr  <= tx_rd_ptr + (TX_AW+1)'(1);
      end
      if (tx_push) tx_wr_ptr <= tx_wr_ptr + (TX_AW+1)'(1);
      if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + (RX_AW+1)'(1);
      if (rx_push) rx_wr_ptr <= rx_wr_ptr + (RX_AW+1)'(1);
      // A new overflow event wins over a simultaneous write-1-to-clear.
      tx_ovf <= tx_ovf_set || (tx_ovf && !(wr_status && bus_wdata[4]));
      rx_ovr <= rx_ovr_set || (rx_ovr && !(wr_status && bus_wdata[3]));
      if (wr_ctrl) begin
        rx_ie <= bus_wdata[0];
        tx_ie <= bus_wdata[1];
      end
      if (bus_rd) bus_rdata <= rd_value;
      irq <= (rx_ie && !rx_empty) || (tx_ie && tx_idle);
    end
  end

  // NOTE: FIFO storage is not reset; the pointers alone decide which entries hold valid bytes.
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr_ptr[TX_AW-1:0]] <= bus_wdata;
    if (rx_push) rx_mem[rx_wr_ptr[RX_AW-1:0]] <= sp_data_out;
  end

endmodule
